regfile_wb_sink: RTL
====================

Name: regfile_wb_sink

Overview:
Register-file write side that consumes results from the write-back stage. It accepts one write-back beat per handshake, with an opcode, up to two destination registers and a 32-bit result. It commits the result into a 16x16 register array through a single write port, and serves two combinational read ports to operand fetch. Wide MUL results are split over two cycles. During the second cycle the block applies back-pressure and flags the pending register.

Parameters:
NUM_REGS, 16, number of architectural registers
DATA_W, 16, register width in bits
ADDR_W, 4, register index width (log2 NUM_REGS)
OP_W, 6, opcode width, matching the ALU select field

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_valid  input  1  write-back beat present
wb_ready  output  1  sink can accept a beat this cycle
wb_op  input  OP_W  opcode of the producing instruction
wb_rdst1  input  ADDR_W  destination for result[15:0]
wb_rdst2  input  ADDR_W  destination for result[31:16] (MUL only)
wb_result  input  2*DATA_W  result word; upper half ignored unless MUL
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  DATA_W  read port A data
rd_addr_b  input  ADDR_W  read port B index
rd_data_b  output  DATA_W  read port B data
rd_pending_a  output  1  port A register has an uncommitted high-half write
rd_pending_b  output  1  port B register has an uncommitted high-half write
wr_count  output  16  number of register writes committed, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: all registers = 0, FSM = IDLE, wb_ready = 1, wr_count = 0, pending flags = 0, hi-half holding registers = 0.
- Handshake: a beat transfers on a rising edge where wb_valid && wb_ready. wb_valid while wb_ready=0 is not consumed; the producer holds the beat stable.
- Opcode classes:
  - 0x04–0x06 and 0x08–0x10: narrow. reg[wb_rdst1] <= wb_result[15:0] at the accept edge. wr_count += 1.
  - 0x07 (MUL): wide.
  - 0x00–0x03 and 0x11–0x3F: accepted and dropped. No register write, no count.
- FSM states: IDLE and HI_PEND.
- IDLE:
  - wb_ready = 1.
  - On a MUL accept: write the low half to wb_rdst1, latch wb_result[31:16] and wb_rdst2, then go to HI_PEND. wr_count += 1.
- HI_PEND:
  - wb_ready = 0.
  - On the next edge: write the latched high half to the latched rdst2, go to IDLE. wr_count += 1.
  - HI_PEND lasts exactly 1 cycle, so MUL throughput is one beat per 2 cycles.
- Read ports:
  - Combinational from the array.
  - Write-through bypass: if a read address matches the register being written in the current cycle, rd_data returns the incoming value. In IDLE the incoming value is wb_result[15:0] on an accepted write op; in HI_PEND it is the latched high half.
- Pending flags: rd_pending_x = (state == HI_PEND) && (rd_addr_x == latched rdst2). Operand fetch stalls on this flag. Because of the bypass, the data is already correct in that cycle; the flag exists for hazard logic and verification.
- Boundary conditions:
  - wb_rdst1 == wb_rdst2 on MUL: the final register value is the high half; wr_count still advances by 2.
  - Reads of any index are legal. All registers are writable, including r0.
  - wr_count wraps from 0xFFFF to 0x0000.
  - Reset asserted during HI_PEND: the pending high-half write is discarded and the array is cleared.
  - Reset deassertion is synchronised externally; the block needs no extra logic for it.

Decomposition:
- Shared package holds:
  - opcode constants OP_MOV0, OP_MOV1, OP_LOAD, OP_STORE, OP_ADD through OP_LRSH;
  - helper function is_narrow_write(op) and constant is_wide_write = (op == OP_MUL);
  - FSM state enum {IDLE, HI_PEND}.
- One sub-module is natural: regfile_array, the NUM_REGS x DATA_W storage with one synchronous write port and two asynchronous read ports with bypass.
- The top level holds the handshake, the FSM, the pending logic and wr_count.

Test Plan:
- Reset, then read all 16 indices -> every rd_data = 0x0000, wb_ready = 1, wr_count = 0.
- ADD op=0x04, rdst1=3, result=0x0000_1234 -> the next cycle reads r3 = 0x1234. In the accept cycle, rd_addr_a=3 bypass shows 0x1234. wr_count = 1.
- MUL op=0x07, rdst1=5, rdst2=6, result=0xABCD_0102 -> wb_ready = 0 for exactly 1 cycle, rd_pending on r6 = 1 in that cycle. Final r5 = 0x0102, r6 = 0xABCD, wr_count += 2. A back-to-back ADD held valid is accepted only after wb_ready returns to 1.
- op=0x02 (LOAD) and op=0x20, rdst1=7, result=0xFFFF -> r7 unchanged, wr_count unchanged, each beat accepted in 1 cycle.
- MUL with rdst1 = rdst2 = 9, result=0x1111_2222 -> r9 = 0x2222 after cycle 1 and 0x1111 after cycle 2.
- MUL accepted, then rst_n pulsed low during HI_PEND -> all registers = 0, FSM = IDLE, wb_ready = 1, r6 never written. Then 65536 narrow writes -> wr_count wraps to 0.

Source files
------------

// File: rtl/regfile_wb_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sink_pkg
// Description : Shared constants for the register-file write-back sink:
//               geometry defaults, opcode map, opcode classification helpers
//               and the write FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_sink_pkg;

  localparam int RF_NUM_REGS = 16;
  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_OP_W     = 6;

  localparam logic [RF_OP_W-1:0] OP_MOV0  = 6'h00;
  localparam logic [RF_OP_W-1:0] OP_MOV1  = 6'h01;
  localparam logic [RF_OP_W-1:0] OP_LOAD  = 6'h02;
  localparam logic [RF_OP_W-1:0] OP_STORE = 6'h03;
  localparam logic [RF_OP_W-1:0] OP_ADD   = 6'h04;
  localparam logic [RF_OP_W-1:0] OP_SUB   = 6'h05;
  localparam logic [RF_OP_W-1:0] OP_NEG   = 6'h06;
  localparam logic [RF_OP_W-1:0] OP_MUL   = 6'h07;
  localparam logic [RF_OP_W-1:0] OP_AND   = 6'h08;
  localparam logic [RF_OP_W-1:0] OP_OR    = 6'h09;
  localparam logic [RF_OP_W-1:0] OP_XOR   = 6'h0A;
  localparam logic [RF_OP_W-1:0] OP_NOT   = 6'h0B;
  localparam logic [RF_OP_W-1:0] OP_LSH   = 6'h0C;
  localparam logic [RF_OP_W-1:0] OP_RSH   = 6'h0D;
  localparam logic [RF_OP_W-1:0] OP_ALSH  = 6'h0E;
  localparam logic [RF_OP_W-1:0] OP_ARSH  = 6'h0F;
  localparam logic [RF_OP_W-1:0] OP_LRSH  = 6'h10;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HI_PEND = 1'b1
  } wb_state_e;

  // Single-cycle register writes: the ALU range minus the two-cycle MUL.
  function automatic logic is_narrow_write(input logic [RF_OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LRSH) && (op != OP_MUL);
  endfunction

  function automatic logic is_wide_write(input logic [RF_OP_W-1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_array.sv
`default_nettype none
// ============================================================================
// Module      : regfile_array
// Description : NUM_REGS x DATA_W register storage, one synchronous write
//               port, two combinational read ports with write-through bypass.
// Ports       : clk, rst_n          - clock, async active-low reset (clears all)
//               we, waddr, wdata    - write port, committed at rising edge
//               raddr_a/b, rdata_a/b- read ports, see same-cycle write data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_array
  import regfile_wb_sink_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets operand fetch see a value in the same cycle it is committed.
  always_comb begin
    rdata_a = (we && (raddr_a == waddr)) ? wdata : regs_q[raddr_a];
    rdata_b = (we && (raddr_b == waddr)) ? wdata : regs_q[raddr_b];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sink
// Description : Write-back sink for the register file. Accepts one beat per
//               valid/ready handshake; narrow ops write result[15:0], MUL
//               writes the low half at accept and the high half on the
//               following cycle while back-pressuring the producer.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               wb_valid/wb_ready          - write-back handshake
//               wb_op, wb_rdst1, wb_rdst2  - opcode and destinations
//               wb_result                  - 2*DATA_W result word
//               rd_addr_x/rd_data_x        - combinational read ports A, B
//               rd_pending_x               - read targets pending high half
//               wr_count                   - committed register writes (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sink
  import regfile_wb_sink_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int OP_W     = RF_OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [OP_W-1:0]     wb_op,
  input  logic [ADDR_W-1:0]   wb_rdst1,
  input  logic [ADDR_W-1:0]   wb_rdst2,
  input  logic [2*DATA_W-1:0] wb_result,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_pending_a,
  output logic                rd_pending_b,
  output logic [15:0]         wr_count
);

  wb_state_e           state_q,    state_d;
  logic [DATA_W-1:0]   hi_data_q,  hi_data_d;
  logic [ADDR_W-1:0]   hi_addr_q,  hi_addr_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;

  always_comb begin
    state_d    = state_q;
    hi_data_d  = hi_data_q;
    hi_addr_d  = hi_addr_q;
    wr_count_d = wr_count_q;
    wb_ready   = 1'b0;
    we         = 1'b0;
    waddr      = wb_rdst1;
    wdata      = wb_result[DATA_W-1:0];
    case (state_q)
      IDLE: begin
        wb_ready = 1'b1;
        // Ops outside both classes are accepted here and simply dropped.
        if (wb_valid) begin
          if (is_narrow_write(wb_op)) begin
            we         = 1'b1;
            wr_count_d = wr_count_q + 16'd1;
          end else if (is_wide_write(wb_op)) begin
            we         = 1'b1;
            wr_count_d = wr_count_q + 16'd1;
            hi_data_d  = wb_result[2*DATA_W-1:DATA_W];
            hi_addr_d  = wb_rdst2;
            state_d    = HI_PEND;
          end
        end
      end
      HI_PEND: begin
        // Unconditional: the high half always commits one cycle after accept.
        we         = 1'b1;
        waddr      = hi_addr_q;
        wdata      = hi_data_q;
        wr_count_d = wr_count_q + 16'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_data_q  <= '0;
      hi_addr_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_data_q  <= hi_data_d;
      hi_addr_q  <= hi_addr_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count     = wr_count_q;
  assign rd_pending_a = (state_q == HI_PEND) && (rd_addr_a == hi_addr_q);
  assign rd_pending_b = (state_q == HI_PEND) && (rd_addr_b == hi_addr_q);

  regfile_array #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rd_addr_a),
    .rdata_a (rd_data_a),
    .raddr_b (rd_addr_b),
    .rdata_b (rd_data_b)
  );

endmodule
`default_nettype wire
